// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the serially loaded program memory.
// Optional build macro: PROG_MEM_PARITY_EN (per-word even-parity bit and ld_err).
package prog_mem_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    localparam logic [DEF_DATA_W-1:0] NOP_WORD = '0;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LOAD,
        ST_DONE
    } state_e;

endpackage

// File: rtl/prog_mem_shifter.sv
// Serial-to-parallel word assembler, LSB first; word_valid_o marks the final accepted bit.
// Optional build macro: PROG_MEM_PARITY_EN (adds a trailing even-parity bit and word_err_o).
module prog_mem_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              n_rst_i,
    input  logic              clr_i,
    input  logic              shift_en_i,
    input  logic              bit_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_valid_o
`ifdef PROG_MEM_PARITY_EN
    ,
    output logic              word_err_o
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);
`ifdef PROG_MEM_PARITY_EN
    localparam int LAST = DATA_W;
`else
    localparam int LAST = DATA_W - 1;
`endif

    logic [DATA_W-1:0] sr_q, sr_d, merged;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last;

    // The word is presented combinationally so the top can write it on the same edge.
    always_comb begin
        merged = sr_q;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (cnt_q == CNT_W'(i)) merged[i] = bit_i;
        end
        last         = (cnt_q == CNT_W'(LAST));
        word_valid_o = shift_en_i && last;
`ifdef PROG_MEM_PARITY_EN
        word_err_o   = word_valid_o && ((^sr_q) ^ bit_i);
        word_o       = word_err_o ? '0 : sr_q;
`else
        word_o       = merged;
`endif
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (shift_en_i) begin
            if (last) begin
                sr_d  = '0;
                cnt_d = '0;
            end else begin
                sr_d  = merged;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!n_rst_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_mem.sv
// Program memory with a bit-serial loader; CPU is held in reset while loading.
// Optional build macro: PROG_MEM_PARITY_EN (per-word parity check, sticky ld_err output).
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic              ld_bit,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              cpu_hold
`ifdef PROG_MEM_PARITY_EN
    ,
    output logic              ld_err
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    state_e            state_q;
    logic              ld_ready_q, ld_done_q, cpu_hold_q;
    logic [DATA_W-1:0] word;
    logic              word_valid;
    logic              shift_en, shift_clr;
`ifdef PROG_MEM_PARITY_EN
    logic              word_err;
    logic              ld_err_q;
`endif

    assign shift_en  = (state_q == ST_LOAD) && ld_valid;
    assign shift_clr = (state_q == ST_RUN) && ld_start;

    prog_mem_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk_i        (clk),
        .n_rst_i      (n_rst),
        .clr_i        (shift_clr),
        .shift_en_i   (shift_en),
        .bit_i        (ld_bit),
        .word_o       (word),
        .word_valid_o (word_valid)
`ifdef PROG_MEM_PARITY_EN
        ,
        .word_err_o   (word_err)
`endif
    );

    // A held CPU must only ever fetch NOPs.
    assign data     = (state_q == ST_RUN) ? mem_q[addr] : DATA_W'(NOP_WORD);
    assign ld_ready = ld_ready_q;
    assign ld_done  = ld_done_q;
    assign cpu_hold = cpu_hold_q;
`ifdef PROG_MEM_PARITY_EN
    assign ld_err   = ld_err_q;
`endif

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= ST_RUN;
            wr_ptr_q   <= '0;
            ld_ready_q <= 1'b0;
            ld_done_q  <= 1'b0;
            cpu_hold_q <= 1'b0;
`ifdef PROG_MEM_PARITY_EN
            ld_err_q   <= 1'b0;
`endif
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= DATA_W'(NOP_WORD);
        end else begin
            ld_done_q <= 1'b0;
            if (word_valid) mem_q[wr_ptr_q] <= word;
            case (state_q)
                ST_RUN: begin
                    if (ld_start) begin
                        state_q    <= ST_LOAD;
                        wr_ptr_q   <= '0;
                        ld_ready_q <= 1'b1;
                        cpu_hold_q <= 1'b1;
`ifdef PROG_MEM_PARITY_EN
                        ld_err_q   <= 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
`ifdef PROG_MEM_PARITY_EN
                    if (word_err) ld_err_q <= 1'b1;
`endif
                    if (word_valid) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        if (wr_ptr_q == '1) begin
                            state_q    <= ST_DONE;
                            ld_ready_q <= 1'b0;
                            ld_done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q    <= ST_RUN;
                    cpu_hold_q <= 1'b0;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem: per-cycle comparison against a word-level model.
// Build with +define+PROG_MEM_PARITY_EN to also exercise the parity option.
module tb_prog_mem;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
`ifdef PROG_MEM_PARITY_EN
    localparam int WBITS  = DATA_W + 1;
`else
    localparam int WBITS  = DATA_W;
`endif

    logic              clk = 1'b0;
    logic              n_rst, ld_start, ld_valid, ld_bit;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              ld_ready, ld_done, cpu_hold;
`ifdef PROG_MEM_PARITY_EN
    logic              ld_err;
`endif

    prog_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .addr     (addr),
        .data     (data),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_bit   (ld_bit),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .cpu_hold (cpu_hold)
`ifdef PROG_MEM_PARITY_EN
        ,
        .ld_err   (ld_err)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int last_valid_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    // Word-level model: phase 0 = running, 1 = loading, 2 = load-complete cycle.
    int m_mem [DEPTH];
    int m_phase = 0;
    int m_ptr = 0;
    int m_nbits = 0;
    int m_acc = 0;
    bit m_err = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_step(input logic s, input logic v, input logic b, input logic r);
        if (!r) begin
            m_phase = 0;
            m_err   = 1'b0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        end else if (m_phase == 0) begin
            if (s) begin
                m_phase = 1;
                m_ptr   = 0;
                m_nbits = 0;
                m_acc   = 0;
                m_err   = 1'b0;
            end
        end else if (m_phase == 1) begin
            if (v) begin
                if (m_nbits < DATA_W) m_acc = m_acc + (int'(b) << m_nbits);
                m_nbits++;
                if (m_nbits == WBITS) begin
`ifdef PROG_MEM_PARITY_EN
                    if ((($countones(m_acc) + int'(b)) % 2) != 0) begin
                        m_mem[m_ptr] = 0;
                        m_err = 1'b1;
                    end else begin
                        m_mem[m_ptr] = m_acc;
                    end
`else
                    m_mem[m_ptr] = m_acc;
`endif
                    m_ptr++;
                    m_nbits = 0;
                    m_acc   = 0;
                    if (m_ptr == DEPTH) m_phase = 2;
                end
            end
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic tick(input logic s, input logic v, input logic b, input logic r);
        ld_start = s;
        ld_valid = v;
        ld_bit   = b;
        n_rst    = r;
        if (v) last_valid_cyc = cyc;
        @(posedge clk);
        cyc++;
        model_step(s, v, b, r);
        #1;
    endtask

    // Full load of base+w into word w; optional gaps, stray start, early stop, bad parity.
    task automatic run_load(input int base, input bit gap, input int start_at,
                            input int stop_after, input int bad_word);
        int n;
        logic [DATA_W-1:0] word;
        logic b;
        n = 0;
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        for (int w = 0; w < DEPTH; w++) begin
            word = DATA_W'(base + w);
            for (int i = 0; i < WBITS; i++) begin
                if (i < DATA_W) b = word[i];
                else b = (^word) ^ (w == bad_word);
                if (n == stop_after) return;
                tick(n == start_at, 1'b1, b, 1'b1);
                n++;
                if (gap) tick(1'b0, 1'b0, ~b, 1'b1);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic read_check(input string name, input int a, input int exp);
        addr = ADDR_W'(a);
        #1;
        check(name, int'(data), exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("data", int'(data), (m_phase == 0) ? m_mem[addr] : 0);
            check("ld_ready", int'(ld_ready), int'(m_phase == 1));
            check("ld_done", int'(ld_done), int'(m_phase == 2));
            check("cpu_hold", int'(cpu_hold), int'(m_phase != 0));
`ifdef PROG_MEM_PARITY_EN
            check("ld_err", int'(ld_err), int'(m_err));
`endif
            if (ld_done) begin
                done_cyc = cyc;
                done_cnt++;
            end
        end
    end

    initial begin
        n_rst = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_bit = 1'b0; addr = '0;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;

        // Reset state and empty-memory sweep
        @(negedge clk);
        check("rst_hold", int'(cpu_hold), 0);
        check("rst_ready", int'(ld_ready), 0);
        check("rst_done", int'(ld_done), 0);
        for (int a = 0; a < DEPTH; a++) read_check("rst_mem", a, 0);

        // Contiguous load of 0x01..0x10; start coincides with a discarded valid bit
        done_cnt = 0;
        addr = 4'd3;
        run_load(1, 1'b0, -1, -1, -1);
        @(negedge clk);
        check("done_pulse", int'(ld_done), 1);
        check("done_hold", int'(cpu_hold), 1);
        check("held_nop", int'(data), 0);
        idle(1);
        @(negedge clk);
        check("hold_fall", int'(cpu_hold), 0);
        check("done_once", done_cnt, 1);
        check("done_lat", done_cyc - last_valid_cyc, 1);
        check("model_w3", m_mem[3], 4);
        read_check("w0", 0, 8'h01);
        read_check("w3", 3, 8'h04);
        read_check("w15", 15, 8'h10);

        // Same contents with gaps in ld_valid, after clearing memory via reset
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        read_check("clr_w3", 3, 0);
        run_load(1, 1'b1, -1, -1, -1);
        idle(2);
        for (int a = 0; a < DEPTH; a++) read_check("gap_mem", a, a + 1);

        // Stray ld_start mid-load is ignored, its valid bit is accepted
        done_cnt = 0;
        run_load(8'h40, 1'b0, 20, -1, -1);
        idle(2);
        check("start_ign_done", done_cnt, 1);
        check("start_ign_lat", done_cyc - last_valid_cyc, 1);
        read_check("start_ign_w0", 0, 8'h40);
        read_check("start_ign_w2", 2, 8'h42);
        read_check("start_ign_w15", 15, 8'h4F);

        // Reset after 40 bits: back to RUN, memory cleared, no ld_done
        done_cnt = 0;
        run_load(8'h80, 1'b0, -1, 40, -1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("midrst_hold", int'(cpu_hold), 0);
        check("midrst_ready", int'(ld_ready), 0);
        idle(3);
        check("midrst_nodone", done_cnt, 0);
        for (int a = 0; a < DEPTH; a++) read_check("midrst_mem", a, 0);

`ifdef PROG_MEM_PARITY_EN
        // Word 2 = 0xA5 with wrong parity: stored as 0, ld_err sticky until next start
        done_cnt = 0;
        run_load(8'hA3, 1'b0, -1, -1, 2);
        idle(3);
        check("par_done", done_cnt, 1);
        check("par_err", int'(ld_err), 1);
        read_check("par_w2", 2, 0);
        read_check("par_w1", 1, 8'hA4);
        read_check("par_w3", 3, 8'hA6);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("par_err_clr", int'(ld_err), 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
`endif

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
